// File: rtl/key_event_classifier_if.sv
// Key event bundle: enable and debounced key levels in, per-key event pulses and busy out.
interface key_event_classifier_if;
  logic       en;
  logic [3:0] key_db;
  logic [3:0] short_press;
  logic [3:0] long_press;
  logic [3:0] rpt_press;
  logic       busy;

  modport master (
    output en,
    output key_db,
    input  short_press,
    input  long_press,
    input  rpt_press,
    input  busy
  );

  modport slave (
    input  en,
    input  key_db,
    output short_press,
    output long_press,
    output rpt_press,
    output busy
  );
endinterface

// File: rtl/key_event_classifier.sv
// Per-key press classifier: turns debounced active-low key levels into one-cycle
// short / long / auto-repeat event pulses, one independent FSM and counter per key.
module key_event_classifier #(
  parameter int                 CNT_W      = 26,
  parameter logic [CNT_W-1:0]   LONG_CNT   = 26'd50_000_000,
  parameter logic [CNT_W-1:0]   REPEAT_CNT = 26'd10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_event_classifier_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] LONG = 2'd2;

  localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CNT - ONE;
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - ONE;

  logic [3:0] short_vec;
  logic [3:0] long_vec;
  logic [3:0] rpt_vec;
  logic [3:0] idle_next;
  logic       busy_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             short_reg, short_next;
    logic             long_reg, long_next;
    logic             rpt_reg, rpt_next;

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      short_next = 1'b0;
      long_next  = 1'b0;
      rpt_next   = 1'b0;
      if (!bus.en) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          IDLE: begin
            cnt_next = '0;
            if (!bus.key_db[gi]) state_next = HOLD;
          end
          // Release is checked before the threshold so a release on the
          // threshold edge still counts as a short press.
          HOLD: begin
            if (bus.key_db[gi]) begin
              short_next = 1'b1;
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == LONG_LAST) begin
              long_next  = 1'b1;
              state_next = LONG;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + ONE;
            end
          end
          LONG: begin
            if (bus.key_db[gi]) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == REPEAT_LAST) begin
              rpt_next = 1'b1;
              cnt_next = '0;
            end else begin
              cnt_next = cnt_reg + ONE;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        short_reg <= 1'b0;
        long_reg  <= 1'b0;
        rpt_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        short_reg <= short_next;
        long_reg  <= long_next;
        rpt_reg   <= rpt_next;
      end
    end

    assign idle_next[gi] = (state_next == IDLE);
    assign short_vec[gi] = short_reg;
    assign long_vec[gi]  = long_reg;
    assign rpt_vec[gi]   = rpt_reg;
  end

  // Registered from next-state so busy lines up with the FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= ~&idle_next;
    end
  end

  assign bus.short_press = short_vec;
  assign bus.long_press  = long_vec;
  assign bus.rpt_press   = rpt_vec;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier with LONG_CNT = 8, REPEAT_CNT = 4.
module tb_key_event_classifier;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  key_event_classifier_if bus ();

  key_event_classifier #(
    .CNT_W      (26),
    .LONG_CNT   (26'd8),
    .REPEAT_CNT (26'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] s, input logic [3:0] l,
                     input logic [3:0] r, input logic b);
    checks++;
    assert (bus.short_press === s) else begin
      failures++;
      $error("FAIL %s short_press observed=%b expected=%b", tag, bus.short_press, s);
    end
    checks++;
    assert (bus.long_press === l) else begin
      failures++;
      $error("FAIL %s long_press observed=%b expected=%b", tag, bus.long_press, l);
    end
    checks++;
    assert (bus.rpt_press === r) else begin
      failures++;
      $error("FAIL %s rpt_press observed=%b expected=%b", tag, bus.rpt_press, r);
    end
    checks++;
    assert (bus.busy === b) else begin
      failures++;
      $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, b);
    end
    $display("step %-12s key_db=%b en=%b rst_n=%b short=%b long=%b rpt=%b busy=%b",
             tag, bus.key_db, bus.en, rst_n, bus.short_press, bus.long_press,
             bus.rpt_press, bus.busy);
  endtask

  // n edges with no pulse expected and a fixed busy level.
  task automatic quiet(input string tag, input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, 4'b0000, 4'b0000, 4'b0000, b);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.key_db = 4'b1111;

    // 1. reset state, then reset mid-hold at cnt = 5
    tick();
    tick();
    chk("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    bus.key_db = 4'b1110;
    quiet("t1_hold", 6, 1'b1);             // E0..E5, cnt = 5
    rst_n = 1'b0;
    tick();
    chk("t1_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    quiet("t1_restart", 8, 1'b1);          // fresh E0..E7
    tick();
    chk("t1_long", 4'b0000, 4'b0001, 4'b0000, 1'b1);
    bus.key_db = 4'b1111;
    quiet("t1_rel", 2, 1'b0);

    // 2. key0 short press, 3 low samples
    bus.key_db = 4'b1110;
    quiet("t2_hold", 3, 1'b1);
    bus.key_db = 4'b1111;
    tick();
    chk("t2_short", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    quiet("t2_after", 1, 1'b0);

    // 3. key2 long press with repeats, release at E20 (repeat boundary)
    bus.key_db = 4'b1011;
    quiet("t3_hold", 8, 1'b1);             // E0..E7
    tick();
    chk("t3_long", 4'b0000, 4'b0100, 4'b0000, 1'b1);
    quiet("t3_gap1", 3, 1'b1);
    tick();
    chk("t3_rpt1", 4'b0000, 4'b0000, 4'b0100, 1'b1);
    quiet("t3_gap2", 3, 1'b1);
    tick();
    chk("t3_rpt2", 4'b0000, 4'b0000, 4'b0100, 1'b1);
    quiet("t3_gap3", 3, 1'b1);             // E17..E19
    bus.key_db = 4'b1111;
    tick();
    chk("t3_rel", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // 4a. key1 low E0..E7, high at E8 -> short
    bus.key_db = 4'b1101;
    quiet("t4a_hold", 8, 1'b1);
    bus.key_db = 4'b1111;
    tick();
    chk("t4a_short", 4'b0010, 4'b0000, 4'b0000, 1'b0);

    // 4b. key1 low E0..E8, high at E9 -> long only
    bus.key_db = 4'b1101;
    quiet("t4b_hold", 8, 1'b1);
    tick();
    chk("t4b_long", 4'b0000, 4'b0010, 4'b0000, 1'b1);
    bus.key_db = 4'b1111;
    tick();
    chk("t4b_rel", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // 5a. key1 and key3 together, short on both
    bus.key_db = 4'b0101;
    quiet("t5a_hold", 3, 1'b1);
    bus.key_db = 4'b1111;
    tick();
    chk("t5a_short", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // 5b. key3 held to long while key1 taps
    bus.key_db = 4'b0101;
    quiet("t5b_both", 2, 1'b1);            // E0, E1
    bus.key_db = 4'b0111;
    tick();
    chk("t5b_tap", 4'b0010, 4'b0000, 4'b0000, 1'b1);
    quiet("t5b_hold", 5, 1'b1);            // E3..E7
    tick();
    chk("t5b_long", 4'b0000, 4'b1000, 4'b0000, 1'b1);
    bus.key_db = 4'b1111;
    tick();
    chk("t5b_rel", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // 6. en dropped at cnt = 4, restored with key0 still low
    bus.key_db = 4'b1110;
    quiet("t6_hold", 5, 1'b1);             // E0..E4
    bus.en = 1'b0;
    quiet("t6_dis", 2, 1'b0);
    bus.en = 1'b1;
    quiet("t6_restart", 8, 1'b1);          // restore edge + 7
    tick();
    chk("t6_long", 4'b0000, 4'b0001, 4'b0000, 1'b1);
    bus.key_db = 4'b1111;
    tick();
    chk("t6_rel", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
